// File: rtl/ssd_debug_mux.sv
// Purpose: probe-channel debug display: selects a channel, converts it to decimal, and scans a seven-segment display plus 16 LEDs.
// Latency: DATA_W+2 clocks from channel sample (LOAD) to display update; seg/anode/leds are registered (1 clock).
// Backpressure: none; hold=1 freezes the displayed value, and a channel change during conversion restarts the conversion.
//
// Ports:
//   clk, Reset           clock (rising edge), synchronous active-high reset
//   probe_bus            NUM_CH packed channels, channel k = probe_bus[k*DATA_W +: DATA_W]
//   ssdSel / ledSel      display channel select / LED slice select
//   hold                 1 = stop starting new conversions
//   leds                 registered LED slice of the live channel, or a status word
//   anode / seg          active-low digit enables (one-hot-low) / segments {g,f,e,d,c,b,a}
//   conv_busy / overflow conversion in progress / displayed value >= 10**NUM_DIGITS
module ssd_debug_mux #(
    parameter int NUM_CH      = 16,
    parameter int DATA_W      = 32,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic [NUM_CH*DATA_W-1:0]  probe_bus,
    input  logic [$clog2(NUM_CH)-1:0] ssdSel,
    input  logic [1:0]                ledSel,
    input  logic                      hold,
    output logic [15:0]               leds,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic [6:0]                seg,
    output logic                      conv_busy,
    output logic                      overflow
);
    localparam int SEL_W  = $clog2(NUM_CH);
    localparam int BCD_D  = (DATA_W * 3) / 10 + 1;
    // Keep at least one nibble above the displayed digits so overflow always has a source.
    localparam int BCD_N  = (BCD_D > NUM_DIGITS) ? BCD_D : NUM_DIGITS + 1;
    localparam int BCD_W  = 4 * BCD_N;
    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int DIV_W  = $clog2(REFRESH_DIV + 1);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DISP_W-1:0]   disp_q, disp_d;
    logic                ovf_q, ovf_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]          seg_q, seg_d;
    logic [15:0]         leds_q, leds_d;

    logic [DATA_W-1:0]   ch_val;
    logic [31:0]         ch32;
    logic [NUM_DIGITS-1:0] blank;
    logic                nz;
    logic [3:0]          cur_dig;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Live channel selected by ssdSel; out-of-range selects read as zero.
    always_comb begin
        ch_val = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ssdSel == SEL_W'(k)) ch_val = probe_bus[k*DATA_W +: DATA_W];
        end
        ch32 = '0;
        ch32[DATA_W-1:0] = ch_val;
    end

    assign conv_busy = (state_q == LOAD) || (state_q == SHIFT);

    // Conversion FSM and double-dabble datapath.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        bcd_adj = bcd_q;
        for (int n = 0; n < BCD_N; n++) begin
            if (bcd_q[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
        end
        case (state_q)
            IDLE: if (!hold) state_d = LOAD;
            LOAD: begin
                sel_d   = ssdSel;
                sh_d    = ch_val;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // A channel change invalidates the partial result; restart on the new channel.
                if (ssdSel != sel_q) begin
                    state_d = LOAD;
                end else begin
                    {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
                end
            end
            DONE: begin
                disp_d  = bcd_q[DISP_W-1:0];
                ovf_d   = |bcd_q[BCD_W-1:DISP_W];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Leading-zero blanking: a digit above 0 is blank when it and every higher digit are zero.
    always_comb begin
        nz    = 1'b0;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz       = nz | (disp_q[i*4 +: 4] != 4'd0);
            blank[i] = (i != 0) && !nz;
        end
        cur_dig = disp_q[idx_q*4 +: 4];
    end

    // Refresh divider, digit scan and LED slice.
    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        anode_d = ~(NUM_DIGITS'(1) << idx_q);
        seg_d   = blank[idx_q] ? 7'h7F : seg7(cur_dig);
        case (ledSel)
            2'd0:    leds_d = ch32[15:0];
            2'd1:    leds_d = ch32[31:16];
            2'd2:    leds_d = {ovf_q, conv_busy, hold, 9'b0, state_q, 2'b0};
            default: leds_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            div_q   <= '0;
            idx_q   <= '0;
            anode_q <= '1;
            seg_q   <= 7'h7F;
            leds_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            leds_q  <= leds_d;
        end
    end

    assign leds     = leds_q;
    assign anode    = anode_q;
    assign seg      = seg_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ssd_debug_mux.sv
// Purpose: directed self-checking bench for ssd_debug_mux with a queue scoreboard.
// Latency: expectations are pushed when stimulus is driven and popped when outputs are sampled on the falling edge.
// Backpressure: none; every wait on the DUT is bounded and an expired bound counts as a mismatch.
module tb_ssd_debug_mux;
    localparam int NUM_CH = 16;
    localparam int DATA_W = 32;
    localparam int ND     = 4;
    localparam int RD     = 4;

    logic                     clk = 1'b0;
    logic                     Reset;
    logic [NUM_CH*DATA_W-1:0] probe_bus;
    logic [3:0]               ssdSel;
    logic [1:0]               ledSel;
    logic                     hold;
    logic [15:0]              leds;
    logic [ND-1:0]            anode;
    logic [6:0]               seg;
    logic                     conv_busy;
    logic                     overflow;

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    ssd_debug_mux #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .NUM_DIGITS(ND), .REFRESH_DIV(RD)
    ) dut (
        .clk(clk), .Reset(Reset), .probe_bus(probe_bus), .ssdSel(ssdSel),
        .ledSel(ledSel), .hold(hold), .leds(leds), .anode(anode), .seg(seg),
        .conv_busy(conv_busy), .overflow(overflow)
    );

    always #10 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: seg_of = 7'h40;  1: seg_of = 7'h79;  2: seg_of = 7'h24;
            3: seg_of = 7'h30;  4: seg_of = 7'h19;  5: seg_of = 7'h12;
            6: seg_of = 7'h02;  7: seg_of = 7'h78;  8: seg_of = 7'h00;
            9: seg_of = 7'h10;  default: seg_of = 7'h7F;
        endcase
    endfunction

    task automatic push(input string t, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    task automatic chk(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
            n_mis++;
            $error("FAIL scoreboard_empty observed=%h expected=entry", obs);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_mis++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic set_ch(input int k, input logic [31:0] v);
        probe_bus[k*DATA_W +: DATA_W] = v;
    endtask

    task automatic wait_busy(input logic lvl, input string t);
        int k;
        k = 0;
        while (conv_busy !== lvl && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        assert (conv_busy === lvl) else begin
            n_mis++;
            $error("FAIL %s observed=%b expected=%b", t, conv_busy, lvl);
        end
    endtask

    // Wait until a conversion that started after the last stimulus change has reached the display.
    task automatic new_conv();
        wait_busy(1'b0, "wait_idle");
        wait_busy(1'b1, "wait_start");
        wait_busy(1'b0, "wait_done");
        repeat (3) @(negedge clk);
    endtask

    // Count consecutive conv_busy=1 samples starting at the next conversion.
    task automatic meas_busy(output int n);
        wait_busy(1'b1, "busy_start");
        n = 1;
        @(negedge clk);
        while (conv_busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Scan all digit slots and compare anode/seg against the decimal value.
    task automatic scan_display(input longint val);
        int         dig[ND];
        longint     v;
        longint     p;
        bit         nz;
        logic [6:0] sexp;
        logic [3:0] aexp;
        int         k;
        v = val;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            dig[i] = int'(v % 10);
            v = v / 10;
            p = p * 10;
        end
        push("overflow", (val >= p) ? 32'd1 : 32'd0);
        chk(32'(overflow));
        k = 0;
        while (anode !== 4'b1110 && k < 40) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < ND; i++) begin
            nz = 1'b0;
            for (int j = i; j < ND; j++) nz = nz | (dig[j] != 0);
            sexp = (i > 0 && !nz) ? 7'h7F : seg_of(dig[i]);
            aexp = ~(4'b0001 << i);
            push("anode_slot", 32'(aexp));
            chk(32'(anode));
            push("seg_digit", 32'(sexp));
            chk(32'(seg));
            repeat (RD) @(negedge clk);
        end
        push("anode_wrap", 32'h0000000E);
        chk(32'(anode));
    endtask

    initial begin
        int n;
        Reset     = 1'b1;
        probe_bus = '0;
        ssdSel    = 4'd5;
        ledSel    = 2'd0;
        hold      = 1'b0;
        set_ch(5, 32'd1234);
        set_ch(9, 32'd42);
        repeat (2) @(negedge clk);

        // Reset state
        push("rst_anode", 32'hF);   chk(32'(anode));
        push("rst_seg", 32'h7F);    chk(32'(seg));
        push("rst_leds", 32'h0);    chk(32'(leds));
        push("rst_busy", 32'h0);    chk(32'(conv_busy));
        push("rst_ovf", 32'h0);     chk(32'(overflow));
        Reset = 1'b0;

        // 1234 on channel 5: busy for LOAD + 32 SHIFT cycles
        push("busy_len", 32'd33);
        meas_busy(n);
        chk(32'(n));
        repeat (3) @(negedge clk);
        scan_display(1234);

        // 12345 overflows four digits
        set_ch(5, 32'd12345);
        new_conv();
        scan_display(12345);

        // Reset pulse mid-SHIFT
        wait_busy(1'b0, "pre_rst_idle");
        wait_busy(1'b1, "pre_rst_start");
        repeat (5) @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        push("mid_rst_anode", 32'hF);  chk(32'(anode));
        push("mid_rst_seg", 32'h7F);   chk(32'(seg));
        push("mid_rst_leds", 32'h0);   chk(32'(leds));
        push("mid_rst_busy", 32'h0);   chk(32'(conv_busy));
        push("mid_rst_ovf", 32'h0);    chk(32'(overflow));
        Reset = 1'b0;
        @(negedge clk);
        push("first_anode", 32'hE);    chk(32'(anode));
        push("first_seg", 32'h40);     chk(32'(seg));
        push("first_busy", 32'h1);     chk(32'(conv_busy));
        push("first_leds", 32'h3039);  chk(32'(leds));

        // Single digit: upper digits blanked
        set_ch(5, 32'd7);
        new_conv();
        scan_display(7);

        // Channel switch 5->9 at SHIFT cycle 10 restarts the conversion
        wait_busy(1'b0, "abort_idle");
        wait_busy(1'b1, "abort_start");
        push("abort_busy_len", 32'd44);
        n = 1;
        @(negedge clk);
        while (conv_busy === 1'b1 && n < 200) begin
            n++;
            if (n == 11) ssdSel = 4'd9;
            @(negedge clk);
        end
        chk(32'(n));
        repeat (3) @(negedge clk);
        scan_display(42);

        // hold freezes the displayed value while the channel changes
        hold = 1'b1;
        wait_busy(1'b0, "hold_idle");
        repeat (2) @(negedge clk);
        set_ch(9, 32'hDEADBEEF);
        push("hold_no_conv", 32'd0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (conv_busy === 1'b1) n++;
        end
        chk(32'(n));
        scan_display(42);

        // LED slices on DEADBEEF
        push("led_lo", 32'hBEEF);    ledSel = 2'd0; @(negedge clk); chk(32'(leds));
        push("led_hi", 32'hDEAD);    ledSel = 2'd1; @(negedge clk); chk(32'(leds));
        push("led_zero", 32'h0000);  ledSel = 2'd3; @(negedge clk); chk(32'(leds));
        push("led_status", 32'h2000); ledSel = 2'd2; @(negedge clk); chk(32'(leds));

        // Release hold: DEADBEEF = 3735928559 shows 8559 with overflow
        ledSel = 2'd0;
        hold   = 1'b0;
        new_conv();
        scan_display(64'd3735928559);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
